// File: rtl/data_sync_pkg.sv
// data_sync_pkg: shared constants and helpers for the data_sync bus synchronizer.
// Optional parity support in the users of this package is enabled by DATA_SYNC_PARITY_EN.
package data_sync_pkg;

  // Legal depth range of the enable synchronizer chain.
  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;

  // Widest bus the parity helper covers; narrower buses are zero-extended.
  localparam int PARITY_MAX_WIDTH = 64;

  // Value every bit of the captured bus takes while in reset.
  localparam logic BUS_RESET_BIT = 1'b0;

  // Even parity: XOR of all bits. Zero-extension does not change the result.
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/data_sync_if.sv
// data_sync_if: source-to-destination bus bundle for data_sync.
// The parity_in / parity_err pair exists only when DATA_SYNC_PARITY_EN is defined.
interface data_sync_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic [BUS_WIDTH-1:0] sync_bus;
  logic                 enable_pulse;
`ifdef DATA_SYNC_PARITY_EN
  logic                 parity_in;
  logic                 parity_err;
`endif

  // Source side: drives the quasi-static bus and its qualifier.
  modport master (
    output unsync_bus,
    output bus_enable,
    input  sync_bus,
    input  enable_pulse
`ifdef DATA_SYNC_PARITY_EN
    ,
    output parity_in,
    input  parity_err
`endif
  );

  // Synchronizer side: samples the bus and presents the captured word.
  modport slave (
    input  unsync_bus,
    input  bus_enable,
    output sync_bus,
    output enable_pulse
`ifdef DATA_SYNC_PARITY_EN
    ,
    input  parity_in,
    output parity_err
`endif
  );

endinterface

// File: rtl/data_sync_bit_sync.sv
// bit_sync: NUM_STAGES-deep single-bit synchronizer chain with async active-high reset.
module bit_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] sync_ff_r;

  // Shift the asynchronous input through the chain; stage 0 is the metastable one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff_r <= {NUM_STAGES{1'b0}};
    end else begin
      sync_ff_r <= {sync_ff_r[NUM_STAGES-2:0], d};
    end
  end

  assign q = sync_ff_r[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// data_sync: carries a quasi-static bus into the clk domain by synchronizing only its
// enable, capturing the bus on the synchronized rising edge and strobing enable_pulse.
// Define DATA_SYNC_PARITY_EN to also capture parity_in and flag parity_err.
module data_sync
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic         clk,
  input  logic         reset,
  data_sync_if.slave   bus
);

  if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_num_stages
    $error("data_sync: NUM_STAGES must lie in 2..4");
  end

  logic                 sync_en_s;
  logic                 rise_s;
  logic                 pulse_gen_r;
  logic [BUS_WIDTH-1:0] sync_bus_r;
  logic                 enable_pulse_r;

  bit_sync #(
    .NUM_STAGES (NUM_STAGES)
  ) u_en_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.bus_enable),
    .q     (sync_en_s)
  );

  // Remember last synchronized enable so only its rising edge is acted on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_gen_r <= 1'b0;
    end else begin
      pulse_gen_r <= sync_en_s;
    end
  end

  assign rise_s = sync_en_s & ~pulse_gen_r;

  // Capture the bus on a rising edge, otherwise recirculate; strobe alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_bus_r     <= {BUS_WIDTH{BUS_RESET_BIT}};
      enable_pulse_r <= 1'b0;
    end else begin
      sync_bus_r     <= rise_s ? bus.unsync_bus : sync_bus_r;
      enable_pulse_r <= rise_s;
    end
  end

  assign bus.sync_bus     = sync_bus_r;
  assign bus.enable_pulse = enable_pulse_r;

`ifdef DATA_SYNC_PARITY_EN
  if (BUS_WIDTH > PARITY_MAX_WIDTH) begin : g_bad_bus_width
    $error("data_sync: BUS_WIDTH exceeds the parity helper width");
  end

  logic parity_err_r;

  // parity_in travels with the bus (same qualifier), so it is checked at the same capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= rise_s
                    ? (even_parity(PARITY_MAX_WIDTH'(bus.unsync_bus)) ^ bus.parity_in)
                    : parity_err_r;
    end
  end

  assign bus.parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_data_sync.sv
// tb_data_sync: directed self-checking bench for data_sync (default 2-stage/8-bit
// instance plus a 3-stage/16-bit instance); parity tests build with DATA_SYNC_PARITY_EN.
module tb_data_sync;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  data_sync_if #(.BUS_WIDTH(8))  ifc ();
  data_sync_if #(.BUS_WIDTH(16)) ifw ();

  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  data_sync #(.NUM_STAGES(3), .BUS_WIDTH(16)) dut_wide (
    .clk   (clk),
    .reset (reset),
    .bus   (ifw.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    ifc.bus_enable = 1'b1;
    ifc.unsync_bus = 8'hA5;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (ifc.sync_bus !== 8'h00 || ifc.enable_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: sync_bus=%h pulse=%b, want 00/0", ifc.sync_bus, ifc.enable_pulse);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ifc.sync_bus !== 8'h00 || ifc.enable_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold%0d: sync_bus=%h pulse=%b, want 00/0", i, ifc.sync_bus, ifc.enable_pulse);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (ifc.enable_pulse !== (e == 3)) begin
        errors++;
        $display("FAIL reset_release_pulse E%0d: got %b want %b", e, ifc.enable_pulse, (e == 3));
      end
      if (e == 3) begin
        checks++;
        if (ifc.sync_bus !== 8'hA5) begin
          errors++;
          $display("FAIL reset_release_bus: got %h want a5", ifc.sync_bus);
        end
      end
    end
    ifc.bus_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ifc.enable_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset_fall_nopulse%0d: got %b want 0", i, ifc.enable_pulse);
      end
    end
  endtask

  task automatic test_single();
    ifc.unsync_bus = 8'h3C;
    ifc.bus_enable = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (ifc.enable_pulse !== (e == 3)) begin
        errors++;
        $display("FAIL single_pulse E%0d: got %b want %b", e, ifc.enable_pulse, (e == 3));
      end
      checks++;
      if (ifc.sync_bus !== ((e >= 3) ? 8'h3C : 8'hA5)) begin
        errors++;
        $display("FAIL single_bus E%0d: got %h want %h", e, ifc.sync_bus, ((e >= 3) ? 8'h3C : 8'hA5));
      end
    end
    ifc.bus_enable = 1'b0;
    ifc.unsync_bus = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ifc.enable_pulse !== 1'b0 || ifc.sync_bus !== 8'h3C) begin
        errors++;
        $display("FAIL single_hold%0d: pulse=%b bus=%h want 0/3c", i, ifc.enable_pulse, ifc.sync_bus);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int         strobes;
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    strobes  = 0;
    for (int w = 0; w < 3; w++) begin
      ifc.unsync_bus = words[w];
      ifc.bus_enable = 1'b1;
      for (int e = 1; e <= 6; e++) begin
        tick();
        if (ifc.enable_pulse === 1'b1) strobes++;
        checks++;
        if (ifc.enable_pulse !== (e == 3)) begin
          errors++;
          $display("FAIL b2b_pulse w%0d E%0d: got %b want %b", w, e, ifc.enable_pulse, (e == 3));
        end
        if (e == 3) begin
          checks++;
          if (ifc.sync_bus !== words[w]) begin
            errors++;
            $display("FAIL b2b_bus w%0d: got %h want %h", w, ifc.sync_bus, words[w]);
          end
          ifc.bus_enable = 1'b0;
        end
      end
    end
    checks++;
    if (strobes != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 3", strobes);
    end
  endtask

  task automatic test_reset_mid();
    ifc.unsync_bus = 8'h5A;
    ifc.bus_enable = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (ifc.sync_bus !== 8'h00 || ifc.enable_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: bus=%h pulse=%b want 00/0", ifc.sync_bus, ifc.enable_pulse);
    end
    ifc.bus_enable = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifc.enable_pulse !== 1'b0 || ifc.sync_bus !== 8'h00) begin
        errors++;
        $display("FAIL mid_reset_quiet%0d: pulse=%b bus=%h want 0/00", i, ifc.enable_pulse, ifc.sync_bus);
      end
    end
  endtask

  task automatic test_wide();
    ifw.unsync_bus = 16'hBEEF;
    ifw.bus_enable = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (ifw.enable_pulse !== (e == 4)) begin
        errors++;
        $display("FAIL wide_pulse E%0d: got %b want %b", e, ifw.enable_pulse, (e == 4));
      end
      checks++;
      if (ifw.sync_bus !== ((e >= 4) ? 16'hBEEF : 16'h0000)) begin
        errors++;
        $display("FAIL wide_bus E%0d: got %h want %h", e, ifw.sync_bus, ((e >= 4) ? 16'hBEEF : 16'h0000));
      end
    end
    ifw.bus_enable = 1'b0;
    repeat (4) tick();
  endtask

`ifdef DATA_SYNC_PARITY_EN
  task automatic parity_word(input logic [7:0] word, input logic par, input logic exp_err, input string name);
    ifc.unsync_bus = word;
    ifc.parity_in  = par;
    ifc.bus_enable = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 3) begin
        checks++;
        if (ifc.enable_pulse !== 1'b1 || ifc.parity_err !== exp_err) begin
          errors++;
          $display("FAIL %s: pulse=%b parity_err=%b want 1/%b", name, ifc.enable_pulse, ifc.parity_err, exp_err);
        end
        ifc.bus_enable = 1'b0;
      end else if (e > 3) begin
        checks++;
        if (ifc.parity_err !== exp_err) begin
          errors++;
          $display("FAIL %s_hold E%0d: parity_err=%b want %b", name, e, ifc.parity_err, exp_err);
        end
      end
    end
  endtask

  task automatic test_parity();
    parity_word(8'h01, 1'b1, 1'b0, "parity_ok");
    parity_word(8'h01, 1'b0, 1'b1, "parity_bad");
    parity_word(8'h03, 1'b0, 1'b0, "parity_clear");
  endtask
`endif

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b0;
    ifc.unsync_bus = 8'h00;
    ifc.bus_enable = 1'b0;
    ifw.unsync_bus = 16'h0000;
    ifw.bus_enable = 1'b0;
`ifdef DATA_SYNC_PARITY_EN
    ifc.parity_in  = 1'b0;
    ifw.parity_in  = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_wide();
`ifdef DATA_SYNC_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sync.md
# data_sync

Multi-bit bus synchronizer for the destination clock domain, placed directly downstream of the reset synchronizer. It uses that stage's synchronized active-high reset output as its reset. It carries a quasi-static data bus across a clock boundary by synchronizing only a single-bit enable through an N-flop chain. It captures the bus on the synchronized rising edge and emits a one-cycle pulse marking each new valid word.

## Interface
- NUM_STAGES, 2, flops in the enable synchronizer chain; legal range 2..4
- BUS_WIDTH, 8, width of the data bus
- clk  input  1  destination-domain clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset; driven by the reset synchronizer's SYNC_RST in this domain
- unsync_bus  input  BUS_WIDTH  source-domain data; stable while bus_enable is high
- bus_enable  input  1  source-domain level qualifier; high for at least NUM_STAGES+1 clk cycles per word, low at least NUM_STAGES+1 cycles between words
- sync_bus  output  BUS_WIDTH  captured data, held until the next capture
- enable_pulse  output  1  single-cycle strobe coincident with each sync_bus update
- parity_in  input  1  present only with DATA_SYNC_PARITY_EN; even parity of unsync_bus
- parity_err  output  1  present only with DATA_SYNC_PARITY_EN

## Operation
- Enable chain: sync_ff[0] samples bus_enable; sync_ff[k] samples sync_ff[k-1]; sync_en = sync_ff[NUM_STAGES-1].
- Edge detect: pulse_gen_ff holds the previous sync_en; rise = sync_en & ~pulse_gen_ff.
- Capture: on rise, sync_bus <= unsync_bus. Otherwise sync_bus holds its value (mux-recirculating flop).
- enable_pulse <= rise, registered and glitch-free.
- Only rising edges of bus_enable produce strobes. A falling edge produces no output activity.
- Reset values while reset is high: sync_ff all 0, pulse_gen_ff 0, sync_bus all 0, enable_pulse 0, parity_err 0.
- Reset asserted mid-transfer clears the chain immediately. A bus_enable still high at reset release is treated as a new rising edge and produces exactly one strobe after the full latency.
- Glitches on bus_enable shorter than one clk period may or may not produce a strobe. They never produce more than one strobe per resolved rising edge.
- Protocol violations are outside the guaranteed behaviour. A bus changing while bus_enable is high may capture a mixed word; this is not detected.

## Timing
- Let E1 be the first clk edge at which bus_enable is sampled high.
- sync_en rises at edge E(NUM_STAGES).
- enable_pulse and sync_bus update at edge E(NUM_STAGES+1): edge E3 for the default configuration.
- enable_pulse is high for exactly one clk cycle.
- Throughput is at most one word per 2*(NUM_STAGES+1) cycles, from the high/low minimums.

## Configuration
- DATA_SYNC_PARITY_EN defined:
  - parity_in is synchronized alongside the bus, with no extra chain.
  - On capture, parity_err <= ^unsync_bus ^ parity_in.
  - parity_err holds until the next capture.
  - It has the same timing as enable_pulse.
- DATA_SYNC_PARITY_EN undefined: parity_in and parity_err do not exist, and no parity logic is synthesized.

## Structure
- Shared package data_sync_pkg:
  - NUM_STAGES legal-range constants (MIN_STAGES=2, MAX_STAGES=4)
  - reset-value constant for the bus
  - even-parity function
- Sub-module bit_sync: parameterised NUM_STAGES flop chain with async active-high reset. Reused for sync_ff and for any other single-bit crossing.
- Elaboration-time check in data_sync rejects NUM_STAGES outside 2..4.

## Test plan
- Reset: assert reset with bus_enable=1, unsync_bus=8'hA5 -> sync_bus=8'h00 and enable_pulse=0 immediately and throughout. Release reset -> one strobe NUM_STAGES+1 edges later, with sync_bus=8'hA5.
- Single transfer, NUM_STAGES=2: unsync_bus=8'h3C, bus_enable high for 4 cycles from E1 -> enable_pulse high only in cycle E3..E4, sync_bus=8'h3C from E3, held after bus changes to 8'hFF.
- Back-to-back words 8'h11, 8'h22, 8'h33 with minimum spacing -> exactly three strobes, sync_bus sequence 11, 22, 33, no strobe on falling edges.
- Reset mid-operation: assert reset at edge E2 of a transfer -> no strobe, outputs zero. Deassert with bus_enable low -> no strobe.
- NUM_STAGES=3, BUS_WIDTH=16: word 16'hBEEF -> strobe at E4 and sync_bus=16'hBEEF.
- DATA_SYNC_PARITY_EN: 8'h01 with parity_in=1 -> parity_err=0 at the strobe. 8'h01 with parity_in=0 -> parity_err=1, held until the next capture.
